// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshakes on both sides, equality/zero flags and a saturating count of
// delivered beats whose operands were equal.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             eq,
    output logic             zero,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             clr_cnt
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] W_ZERO   = '0;

    // Bitwise function selected by the opcode captured with the operands.
    function automatic logic [WIDTH-1:0] f_compute(input logic [2:0] f_op,
                                                   input logic [WIDTH-1:0] f_a,
                                                   input logic [WIDTH-1:0] f_b);
        logic [WIDTH-1:0] r;
        case (f_op)
            OP_AND:  r = f_a & f_b;
            OP_OR:   r = f_a | f_b;
            OP_XOR:  r = f_a ^ f_b;
            OP_XNOR: r = f_a ~^ f_b;
            OP_NAND: r = ~(f_a & f_b);
            OP_NOR:  r = ~(f_a | f_b);
            OP_NOTA: r = ~f_a;
            OP_PASS: r = f_a;
            default: r = W_ZERO;
        endcase
        return r;
    endfunction

    // Operands are equal exactly when every bit of their XNOR is one.
    function automatic logic f_all_equal(input logic [WIDTH-1:0] f_a,
                                         input logic [WIDTH-1:0] f_b);
        return &(f_a ~^ f_b);
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_y_q, s2_y_d;
    logic             s2_eq_q, s2_eq_d;
    logic             s2_zero_q, s2_zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s1_advance_s;
    logic             in_ready_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [WIDTH-1:0] y_calc_s;

    // Handshake decode: S1 may drain into S2 when S2 is empty or being consumed.
    always_comb begin
        s1_advance_s = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready_s   = rst_n && (!s1_valid_q || s1_advance_s);
        in_xfer_s    = in_valid && in_ready_s;
        out_xfer_s   = s2_valid_q && out_ready;
        y_calc_s     = f_compute(s1_op_q, s1_a_q, s1_b_q);
    end

    // S1 next state: capture operands only on an accepted beat, else hold data.
    always_comb begin
        s1_op_d = s1_op_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        if (in_xfer_s) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op;
            s1_a_d     = a;
            s1_b_d     = b;
        end else if (s1_advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: load the computed result when S1 advances, hold under backpressure.
    always_comb begin
        s2_y_d    = s2_y_q;
        s2_eq_d   = s2_eq_q;
        s2_zero_d = s2_zero_q;
        if (s1_advance_s) begin
            s2_valid_d = 1'b1;
            s2_y_d     = y_calc_s;
            s2_eq_d    = f_all_equal(s1_a_q, s1_b_q);
            s2_zero_d  = (y_calc_s == W_ZERO);
        end else if (out_xfer_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Match counter next state: clear beats increment, increment saturates.
    always_comb begin
        if (clr_cnt) begin
            cnt_d = CNT_ZERO;
        end else if (out_xfer_s && s2_eq_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset discarding in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'b000;
            s1_a_q     <= W_ZERO;
            s1_b_q     <= W_ZERO;
            s2_valid_q <= 1'b0;
            s2_y_q     <= W_ZERO;
            s2_eq_q    <= 1'b0;
            s2_zero_q  <= 1'b0;
            cnt_q      <= CNT_ZERO;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_eq_q    <= s2_eq_d;
            s2_zero_q  <= s2_zero_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign y         = s2_y_q;
    assign eq        = s2_eq_q;
    assign zero      = s2_zero_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe. Three instances share one stimulus
// stream: WIDTH=8/CNT_W=16, WIDTH=8/CNT_W=2 (saturation) and WIDTH=1 (bit 0).
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready, clr_cnt;
    logic [2:0] op;
    logic [7:0] a, b;

    logic        in_ready0, out_valid0, eq0, zero0;
    logic [7:0]  y0;
    logic [15:0] cnt0;
    logic        in_ready1, out_valid1, eq1, zero1;
    logic [7:0]  y1;
    logic [1:0]  cnt1;
    logic        in_ready2, out_valid2, eq2, zero2;
    logic [0:0]  y2;
    logic [15:0] cnt2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 1'b0;

    typedef struct {
        logic [7:0] y;
        logic       eq;
        logic       zero;
        logic       yb;
        logic       eqb;
        logic       zerob;
        int         acc;
    } exp_t;
    exp_t sb[$];

    // Truth table per opcode, indexed by {a_bit, b_bit}.
    localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001,
                                      4'b0111, 4'b0001, 4'b0011, 4'b1100};

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .y(y0), .eq(eq0), .zero(zero0), .match_cnt(cnt0), .clr_cnt(clr_cnt));

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .y(y1), .eq(eq1), .zero(zero1), .match_cnt(cnt1), .clr_cnt(clr_cnt));

    logic_unit_pipe #(.WIDTH(1), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .a(a[0:0]), .b(b[0:0]), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .eq(eq2), .zero(zero2), .match_cnt(cnt2), .clr_cnt(clr_cnt));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_y(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        logic [3:0] tt;
        logic [7:0] r;
        tt = TT[o];
        for (int i = 0; i < 8; i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    // Called at the negedge before the accepting edge.
    task automatic push_exp(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        exp_t e;
        e.y     = model_y(o, x, z);
        e.eq    = (x == z);
        e.zero  = (e.y == 8'h00);
        e.yb    = e.y[0];
        e.eqb   = (x[0] == z[0]);
        e.zerob = ~e.y[0];
        e.acc   = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        int tries;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = z;
        @(negedge clk);
        tries = 0;
        while (!in_ready0 && tries < 50) begin
            @(posedge clk); @(negedge clk);
            tries++;
        end
        if (!in_ready0) chk("send_timeout", 32'd1, 32'd0);
        else push_exp(o, x, z);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // Monitor: pops the scoreboard on each delivered beat and tracks counters.
    initial begin : monitor
        int m16, m2, m1, last_pop;
        bit exp_v;
        exp_t e;
        m16 = 0; m2 = 0; m1 = 0; last_pop = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (!rst_n) begin
                    sb.delete();
                    m16 = 0; m2 = 0; m1 = 0; last_pop = 0;
                end else begin
                    chk("cnt16", cnt0, m16);
                    chk("cnt2", cnt1, m2);
                    chk("cnt_w1", cnt2, m1);
                    exp_v = (sb.size() > 0) && (cyc >= last_pop) && (cyc >= sb[0].acc + 1);
                    chk("out_valid0", out_valid0, exp_v);
                    chk("out_valid1", out_valid1, exp_v);
                    chk("out_valid2", out_valid2, exp_v);
                    if (exp_v) begin
                        e = sb[0];
                        chk("y0", y0, e.y);
                        chk("eq0", eq0, e.eq);
                        chk("zero0", zero0, e.zero);
                        chk("y1", y1, e.y);
                        chk("y_w1", y2, e.yb);
                        chk("eq_w1", eq2, e.eqb);
                        chk("zero_w1", zero2, e.zerob);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            last_pop = cyc + 1;
                            if (e.eq && m16 < 65535) m16++;
                            if (e.eq && m2 < 3) m2++;
                            if (e.eqb && m1 < 65535) m1++;
                        end
                    end
                    if (clr_cnt) begin
                        m16 = 0; m2 = 0; m1 = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit         pending;
        logic [2:0] ro;
        logic [7:0] ra, rb;
        int         tries;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        op = 3'b000; a = 8'h00; b = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_y", y0, 8'h00);
        chk("rst_eq", eq0, 1'b0);
        chk("rst_zero", zero0, 1'b0);
        chk("rst_cnt", cnt0, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        armed = 1'b1;

        // All eight opcodes back-to-back, first result two cycles after issue
        send(3'b000, 8'hA5, 8'h0F);
        idle(0);
        for (int i = 1; i < 8; i++) begin
            send(3'(i), 8'hA5, 8'h0F);
            if (i == 1) chk("lat_not_early", out_valid0, 1'b0);
            if (i == 2) begin
                chk("lat_first", out_valid0, 1'b1);
                chk("lat_first_y", y0, 8'h05);
            end
        end
        idle(4);

        // Equality flag, zero flag and match counter
        send(3'b011, 8'h3C, 8'h3C);
        send(3'b000, 8'h3C, 8'hC3);
        idle(4);
        chk("cnt_after_eq", cnt0, 16'd1);

        // Backpressure: two beats fill the pipe, third waits
        @(posedge clk); #1; out_ready = 1'b0;
        send(3'b010, 8'h11, 8'h22);
        send(3'b001, 8'h40, 8'h04);
        @(posedge clk); #1;
        in_valid = 1'b1; op = 3'b111; a = 8'h77; b = 8'h00;
        @(negedge clk);
        chk("bp_full", in_ready0, 1'b0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("bp_hold", in_ready0, 1'b0);
            chk("bp_y", y0, 8'h33);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", in_ready0, 1'b1);
        push_exp(3'b111, 8'h77, 8'h00);
        idle(5);

        // Counter saturation on the CNT_W=2 instance, then clear vs increment
        @(posedge clk); #1; clr_cnt = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ra = 8'($urandom);
            send(3'($urandom_range(0, 7)), ra, ra);
        end
        idle(4);
        chk("sat_cnt2", cnt1, 2'd3);
        chk("sat_cnt16", cnt0, 16'd5);
        send(3'b011, 8'h5A, 8'h5A);
        idle(1);
        @(posedge clk); #1; in_valid = 1'b0; clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr_deliver", out_valid0, 1'b1);
        @(posedge clk); #1; clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_wins", cnt1, 2'd0);

        // Reset with two beats in flight
        @(posedge clk); #1; out_ready = 1'b0;
        send(3'b011, 8'h12, 8'h12);
        send(3'b001, 8'h34, 8'h56);
        @(posedge clk); #1; rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready0, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("mid_rst_out_valid", out_valid0, 1'b0);
        chk("mid_rst_y", y0, 8'h00);
        chk("mid_rst_cnt", cnt0, 16'h0000);
        @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
        send(3'b001, 8'hFF, 8'h00);
        idle(1);
        chk("post_rst_early", out_valid0, 1'b0);
        idle(1);
        chk("post_rst_valid", out_valid0, 1'b1);
        chk("post_rst_y", y0, 8'hFF);
        idle(2);

        // WIDTH=1 exhaustive XNOR on bit 0
        for (int i = 0; i < 4; i++) begin
            ra = {7'($urandom), 1'(i >> 1)};
            rb = {7'($urandom), 1'(i)};
            send(3'b011, ra, rb);
        end
        idle(4);

        // Randomized traffic with random backpressure and clears
        pending = 1'b0; ro = 3'b000; ra = 8'h00; rb = 8'h00;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (!pending && ($urandom_range(0, 3) != 0)) begin
                pending = 1'b1;
                ro = 3'($urandom_range(0, 7));
                ra = 8'($urandom);
                rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
            end
            in_valid  = pending;
            op = ro; a = ra; b = rb;
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            if (in_valid && in_ready0) begin
                push_exp(ro, ra, rb);
                pending = 1'b0;
            end
        end

        // Drain
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        tries = 0;
        while (sb.size() > 0 && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        chk("drain_out_valid", out_valid0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
